// File: rtl/stn_cap_buf_pkg.sv
// Shared definitions for the STN capture buffer.
// Holds the capture FSM state type and the default sizing constants
// used by the interface, the RAM and the top level.
package stn_cap_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } cap_state_t;

    localparam int DEPTH_DEF = 6080;   // bytes held, 0x0000..0x17BF
    localparam int AW_DEF    = 13;
    localparam int SYNC_DEF  = 2;      // synchronizer depth on the STN inputs

endpackage

// File: rtl/stn_cap_buf_if.sv
// Read port between the TFT timing generator (master) and the capture
// buffer (slave).
//   fifo_rdreq  master -> slave  read request
//   fifo_raddr  master -> slave  read byte address
//   fifo_rdack  slave -> master  read grant (combinational)
//   fifo_rdata  slave -> master  read data, valid the cycle after the grant
interface stn_cap_buf_if
    import stn_cap_pkg::*;
#(
    parameter int AW = AW_DEF
);
    logic          fifo_rdreq;
    logic          fifo_rdack;
    logic [AW-1:0] fifo_raddr;
    logic [7:0]    fifo_rdata;

    modport master (
        output fifo_rdreq,
        output fifo_raddr,
        input  fifo_rdack,
        input  fifo_rdata
    );

    modport slave (
        input  fifo_rdreq,
        input  fifo_raddr,
        output fifo_rdack,
        output fifo_rdata
    );
endinterface

// File: rtl/stn_cap_buf_ram.sv
// Single-port synchronous byte RAM with registered read data.
//   clk, rst  clock and synchronous reset (clears the read register only)
//   we        write enable, takes priority over re
//   re        read enable; rdata updates on the next edge
//   addr      shared read/write address
//   wdata     write byte
//   rdata     registered read byte, holds between reads
module stn_cap_ram
    import stn_cap_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 8'h00;
        end else if (re && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/stn_cap_buf.sv
// STN panel bus capture into a frame/line buffer feeding the TFT timing
// generator. Nibble pairs on the STN bus are packed MSB-first into bytes
// and written into a single-port RAM; the read port is served whenever
// no write is pending.
//   clk, rst        system clock, synchronous active-high reset
//   cap_en          capture enable; low forces IDLE
//   stn_fpframe     frame pulse (async)
//   stn_fpline      line latch (async)
//   stn_fpshift     shift clock (async), data taken on its falling edge
//   stn_data        pixel nibble (async)
//   fifo            read port (slave side)
//   cap_active      high in CAPTURE
//   cap_waddr       next write address
//   cap_err         sticky odd-nibble-at-line-end flag
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | waiting for a frame pulse with cap_en high
//   CAPTURE | packing nibbles and writing bytes to the buffer
module stn_cap_buf
    import stn_cap_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cap_en,
    input  logic            stn_fpframe,
    input  logic            stn_fpline,
    input  logic            stn_fpshift,
    input  logic [3:0]      stn_data,
    stn_cap_buf_if.slave    fifo,
    output logic            cap_active,
    output logic [AW-1:0]   cap_waddr,
    output logic            cap_err
);

    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    // {fpframe, fpline, fpshift, data[3:0]} through the synchronizer
    logic [SYNC_STAGES-1:0][6:0] sync_q;
    logic [2:0]                  hist_q;
    logic [6:0]                  s_now;
    logic                        frm_rise;
    logic                        lin_fall;
    logic                        shf_fall;
    logic [3:0]                  s_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0],
                       {stn_fpframe, stn_fpline, stn_fpshift, stn_data}};
            hist_q <= sync_q[SYNC_STAGES-1][6:4];
        end
    end

    assign s_now    = sync_q[SYNC_STAGES-1];
    assign frm_rise = s_now[6] & ~hist_q[2];
    assign lin_fall = ~s_now[5] & hist_q[1];
    assign shf_fall = ~s_now[4] & hist_q[0];
    assign s_data   = s_now[3:0];

    cap_state_t    state;
    logic          phase;
    logic          pending;
    logic [3:0]    hold_nib;
    logic [7:0]    wbyte;
    logic [AW-1:0] waddr;
    logic          err;
    logic          oor_q;

    // The shift is resolved before the line check, so a line fall that
    // coincides with the first nibble of a pair drops that nibble.
    logic shift_ph;
    logic do_write;
    logic line_drop;

    always_comb begin
        shift_ph = phase;
        do_write = 1'b0;
        if (shf_fall) begin
            if (!phase) begin
                shift_ph = 1'b1;
            end else begin
                shift_ph = 1'b0;
                do_write = 1'b1;
            end
        end
        line_drop = lin_fall & shift_ph;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= 1'b0;
            pending  <= 1'b0;
            hold_nib <= 4'h0;
            wbyte    <= 8'h00;
            waddr    <= '0;
            err      <= 1'b0;
        end else begin
            if (pending) begin
                pending <= 1'b0;
                waddr   <= (waddr == LAST_A) ? '0 : waddr + AW'(1);
            end
            case (state)
                IDLE: begin
                    if (cap_en && frm_rise) begin
                        state <= CAPTURE;
                        waddr <= '0;
                        phase <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (!cap_en) begin
                        state   <= IDLE;
                        phase   <= 1'b0;
                        pending <= 1'b0;
                    end else if (frm_rise) begin
                        // frame restart wins over any coincident nibble
                        waddr <= '0;
                        phase <= 1'b0;
                    end else begin
                        if (shf_fall && !phase) begin
                            hold_nib <= s_data;
                        end
                        if (do_write) begin
                            wbyte   <= {hold_nib, s_data};
                            pending <= 1'b1;
                        end
                        phase <= shift_ph & ~lin_fall;
                        if (line_drop) begin
                            err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic          ram_re;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_rdata;
    logic          in_range;

    assign in_range        = fifo.fifo_raddr < DEPTH_A;
    assign fifo.fifo_rdack = fifo.fifo_rdreq & ~pending;
    assign ram_re          = fifo.fifo_rdack & in_range;
    assign ram_addr        = pending ? waddr : fifo.fifo_raddr;

    // Out-of-range reads are granted but never touch the RAM; this flag
    // masks the stale RAM output until the next in-range grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            oor_q <= 1'b0;
        end else if (fifo.fifo_rdack) begin
            oor_q <= ~in_range;
        end
    end

    stn_cap_ram #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (pending),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (wbyte),
        .rdata (ram_rdata)
    );

    assign fifo.fifo_rdata = oor_q ? 8'h00 : ram_rdata;
    assign cap_active      = (state == CAPTURE);
    assign cap_waddr       = waddr;
    assign cap_err         = err;

endmodule
